// File: rtl/sub_mp_seq.sv
// rtl/sub_mp_seq.sv - multi-precision subtract sequencer over a shared 16-bit subtractor (optional flags: SUB_MP_FLAGS_EN)

// 16-bit subtractor slice: bin is active-low borrow in, bout is active-high borrow out.
module sub_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic [15:0] dout,
  output logic        bout
);

  // Bitwise borrow chain: a bit borrows when a<b there, or passes an incoming borrow when a==b.
  always_comb begin
    logic brw;
    dout = '0;
    brw  = ~bin;
    for (int i = 0; i < 16; i++) begin
      dout[i] = a[i] ^ b[i] ^ brw;
      brw     = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw);
    end
    bout = brw;
  end

endmodule

module sub_mp_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   din1,
  input  logic [16*WORDS-1:0]   din2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   dout,
  output logic                  bout,
`ifdef SUB_MP_FLAGS_EN
  output logic                  zero,
  output logic                  ovf,
`endif
  output logic                  busy
);

  localparam int N  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [N-1:0]  op1;
  logic [N-1:0]  op2;
  logic [N-1:0]  result;
  logic [N-1:0]  res_next;
  logic [IW-1:0] idx;
  logic          carry_n;
  logic [15:0]   a_slice;
  logic [15:0]   b_slice;
  logic [15:0]   d_slice;
  logic          bout_slice;

  assign in_ready = (state == IDLE);
  assign dout     = result;
  assign a_slice  = op1[16*idx +: 16];
  assign b_slice  = op2[16*idx +: 16];

  sub_16bit u_sub (
    .a    (a_slice),
    .b    (b_slice),
    .bin  (carry_n),
    .dout (d_slice),
    .bout (bout_slice)
  );

  // Result as it will look once the current slice is written; flags on the last slice see the full value.
  always_comb begin
    res_next = result;
    res_next[16*idx +: 16] = d_slice;
  end

  // Sequencer: capture operands, walk slices LSW first chaining the borrow, hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      op1       <= '0;
      op2       <= '0;
      result    <= '0;
      bout      <= 1'b0;
      idx       <= '0;
      carry_n   <= 1'b1;
`ifdef SUB_MP_FLAGS_EN
      zero      <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op1     <= din1;
            op2     <= din2;
            idx     <= '0;
            carry_n <= 1'b1;
            result  <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          result  <= res_next;
          carry_n <= ~bout_slice;
          if (idx == LAST) begin
            bout      <= bout_slice;
`ifdef SUB_MP_FLAGS_EN
            zero      <= (res_next == '0);
            ovf       <= (op1[N-1] != op2[N-1]) && (res_next[N-1] != op1[N-1]);
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
